// File: rtl/mult_div_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
// Also holds the small sign-handling helpers used by the divide path.
package mult_div_pkg;

  localparam int WIDTH = 32;
  localparam int ITER  = 32;
  localparam int CNT_W = $clog2(ITER + 1);

  localparam logic OP_MULT = 1'b1;
  localparam logic OP_DIV  = 1'b0;

  typedef logic [WIDTH-1:0]   word_t;
  typedef logic [2*WIDTH-1:0] dword_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  // Magnitude of a two's complement word; 0x80000000 maps to itself, read as unsigned 2^31.
  function automatic word_t abs_word(input word_t x);
    if (x[WIDTH-1]) begin
      abs_word = ~x + word_t'(1'b1);
    end else begin
      abs_word = x;
    end
  endfunction

  function automatic word_t neg_if(input word_t x, input logic neg);
    if (neg) begin
      neg_if = ~x + word_t'(1'b1);
    end else begin
      neg_if = x;
    end
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the control unit (master) and the
// multiply/divide unit (slave).
interface mult_div_if;
  import mult_div_pkg::*;

  logic  start;
  logic  op;
  word_t a;
  word_t b;
  word_t hi;
  word_t lo;
  logic  busy;
  logic  done;
  logic  div_zero;

  modport master (
    output start, op, a, b,
    input  hi, lo, busy, done, div_zero
  );

  modport slave (
    input  start, op, a, b,
    output hi, lo, busy, done, div_zero
  );

endinterface

// File: rtl/mult_div_unit_div_step.sv
// One restoring-division step on magnitudes: shift {rem, quot} left, then
// subtract the divisor from the remainder when it fits.
module div_step
  import mult_div_pkg::*;
(
  input  dword_t rem_quot,
  input  word_t  divisor,
  output dword_t rem_quot_nxt
);

  logic [WIDTH:0] rem_sh_s;
  word_t          quot_sh_s;
  word_t          diff_s;
  logic           fits_s;

  // Shifted remainder can reach 2*divisor-1, so it carries one extra bit.
  always_comb begin
    rem_sh_s  = {rem_quot[2*WIDTH-1:WIDTH], rem_quot[WIDTH-1]};
    quot_sh_s = {rem_quot[WIDTH-2:0], 1'b0};
    fits_s    = (rem_sh_s >= {1'b0, divisor});
    diff_s    = rem_sh_s[WIDTH-1:0] - divisor;
    if (fits_s) begin
      rem_quot_nxt = {diff_s, quot_sh_s | word_t'(1'b1)};
    end else begin
      rem_quot_nxt = {rem_sh_s[WIDTH-1:0], quot_sh_s};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Sequential signed multiply (radix-2 Booth) / divide (restoring) unit that
// produces HI/LO for the multicycle datapath, one iteration per clock.
module mult_div_unit
  import mult_div_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  mult_div_if.slave  bus
);

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  dword_t           acc_r, acc_s;
  logic             qm1_r, qm1_s;
  word_t            mcand_r, mcand_s;
  logic             op_r, op_s;
  logic             sign_a_r, sign_a_s;
  logic             sign_b_r, sign_b_s;
  word_t            hi_r, hi_s;
  word_t            lo_r, lo_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             div_zero_r, div_zero_s;

  logic [WIDTH:0]   booth_sum_s;
  dword_t           booth_acc_s;
  logic             booth_qm1_s;
  dword_t           div_nxt_s;

  div_step u_div_step (
    .rem_quot     (acc_r),
    .divisor      (mcand_r),
    .rem_quot_nxt (div_nxt_s)
  );

  // Booth step; the add is one bit wider so -(0x80000000) does not overflow before the shift.
  always_comb begin
    case ({acc_r[0], qm1_r})
      2'b01:   booth_sum_s = {acc_r[2*WIDTH-1], acc_r[2*WIDTH-1:WIDTH]}
                           + {mcand_r[WIDTH-1], mcand_r};
      2'b10:   booth_sum_s = {acc_r[2*WIDTH-1], acc_r[2*WIDTH-1:WIDTH]}
                           - {mcand_r[WIDTH-1], mcand_r};
      default: booth_sum_s = {acc_r[2*WIDTH-1], acc_r[2*WIDTH-1:WIDTH]};
    endcase
    booth_acc_s = {booth_sum_s[WIDTH:1], booth_sum_s[0], acc_r[WIDTH-1:1]};
    booth_qm1_s = acc_r[0];
  end

  // Next-state and datapath update for the IDLE/MULT/DIV/FIX sequencer.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    acc_s      = acc_r;
    qm1_s      = qm1_r;
    mcand_s    = mcand_r;
    op_s       = op_r;
    sign_a_s   = sign_a_r;
    sign_b_s   = sign_b_r;
    hi_s       = hi_r;
    lo_s       = lo_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    div_zero_s = 1'b0;

    case (state_r)
      IDLE: begin
        if (bus.start) begin
          if (bus.op == OP_MULT) begin
            op_s    = OP_MULT;
            mcand_s = bus.a;
            acc_s   = {{WIDTH{1'b0}}, bus.b};
            qm1_s   = 1'b0;
            cnt_s   = CNT_W'(ITER);
            busy_s  = 1'b1;
            state_s = MULT;
          end else if (bus.b != {WIDTH{1'b0}}) begin
            op_s     = OP_DIV;
            mcand_s  = abs_word(bus.b);
            acc_s    = {{WIDTH{1'b0}}, abs_word(bus.a)};
            sign_a_s = bus.a[WIDTH-1];
            sign_b_s = bus.b[WIDTH-1];
            qm1_s    = 1'b0;
            cnt_s    = CNT_W'(ITER);
            busy_s   = 1'b1;
            state_s  = DIV;
          end else begin
            div_zero_s = 1'b1;
            state_s    = IDLE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      MULT: begin
        acc_s = booth_acc_s;
        qm1_s = booth_qm1_s;
        cnt_s = cnt_r - CNT_W'(1'b1);
        if (cnt_r == CNT_W'(1'b1)) begin
          state_s = FIX;
        end else begin
          state_s = MULT;
        end
      end
      DIV: begin
        acc_s = div_nxt_s;
        cnt_s = cnt_r - CNT_W'(1'b1);
        if (cnt_r == CNT_W'(1'b1)) begin
          state_s = FIX;
        end else begin
          state_s = DIV;
        end
      end
      FIX: begin
        if (op_r == OP_MULT) begin
          hi_s = acc_r[2*WIDTH-1:WIDTH];
          lo_s = acc_r[WIDTH-1:0];
        end else begin
          // Truncating division: quotient sign from both operands, remainder follows the dividend.
          lo_s = neg_if(acc_r[WIDTH-1:0], sign_a_r ^ sign_b_r);
          hi_s = neg_if(acc_r[2*WIDTH-1:WIDTH], sign_a_r);
        end
        done_s  = 1'b1;
        busy_s  = 1'b0;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath and output registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      acc_r      <= {(2*WIDTH){1'b0}};
      qm1_r      <= 1'b0;
      mcand_r    <= {WIDTH{1'b0}};
      op_r       <= OP_DIV;
      sign_a_r   <= 1'b0;
      sign_b_r   <= 1'b0;
      hi_r       <= {WIDTH{1'b0}};
      lo_r       <= {WIDTH{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      acc_r      <= acc_s;
      qm1_r      <= qm1_s;
      mcand_r    <= mcand_s;
      op_r       <= op_s;
      sign_a_r   <= sign_a_s;
      sign_b_r   <= sign_b_s;
      hi_r       <= hi_s;
      lo_r       <= lo_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      div_zero_r <= div_zero_s;
    end
  end

  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.div_zero = div_zero_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed operations push expected
// HI/LO into a queue, a monitor pops and compares on done/div_zero.
module tb_mult_div_unit;
  import mult_div_pkg::*;

  typedef struct {
    word_t hi;
    word_t lo;
    logic  dz;
    int    e0;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   busy_cnt = 0;
  exp_t exp_q[$];

  mult_div_if bus();

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one start pulse (sampled at the next rising edge, E0) and record the expectation.
  task automatic issue(input bit sync, input logic op, input word_t a, input word_t b,
                       input word_t eh, input word_t el, input logic dz);
    exp_t e;
    if (sync) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    e.hi = eh;
    e.lo = el;
    e.dz = dz;
    e.e0 = cyc + 1;
    exp_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 32'hDEAD_BEEF;
    bus.b     = 32'h0BAD_F00D;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      chk("timeout_pending", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        busy_cnt = 0;
      end else begin
        if (bus.busy) busy_cnt++;
        if (bus.done || bus.div_zero) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done_or_dz", {62'd0, bus.done, bus.div_zero}, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("div_zero_flag", 64'(bus.div_zero), 64'(e.dz));
            chk("done_flag", 64'(bus.done), 64'(!e.dz));
            chk("hi", 64'(bus.hi), 64'(e.hi));
            chk("lo", 64'(bus.lo), 64'(e.lo));
            chk("latency_edges", 64'(cyc - e.e0), e.dz ? 64'd0 : 64'd33);
            chk("busy_cycles", 64'(busy_cnt), e.dz ? 64'd0 : 64'd33);
            busy_cnt = 0;
          end
        end else if (exp_q.size() == 0) begin
          chk("idle_busy", 64'(bus.busy), 64'd0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start = 1'b0;
    bus.op    = OP_DIV;
    bus.a     = 32'h0;
    bus.b     = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_div_zero", 64'(bus.div_zero), 64'd0);
    reset = 1'b0;

    // Multiplies
    issue(1'b1, OP_MULT, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    wait_idle();
    issue(1'b1, OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
    wait_idle();
    issue(1'b1, OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0);
    wait_idle();
    issue(1'b1, OP_MULT, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0);
    wait_idle();

    // Divides, including sign combinations and the overflow corner
    issue(1'b1, OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    wait_idle();
    issue(1'b1, OP_DIV, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    wait_idle();
    issue(1'b1, OP_DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0);
    wait_idle();
    issue(1'b1, OP_DIV, 32'h0000_0451, 32'h0000_0020, 32'h0000_0011, 32'h0000_0022, 1'b0);
    wait_idle();
    issue(1'b1, OP_DIV, 32'h0000_0005, 32'h0000_0000, 32'h0000_0011, 32'h0000_0022, 1'b1);
    wait_idle();
    issue(1'b1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    wait_idle();

    // Back-to-back: second start lands in the cycle done is high
    issue(1'b1, OP_MULT, 32'h0000_0006, 32'h0000_0007, 32'h0000_0000, 32'h0000_002A, 1'b0);
    for (int i = 0; i < 100 && !bus.done; i++) @(negedge clk);
    chk("b2b_done_seen", 64'(bus.done), 64'd1);
    issue(1'b0, OP_MULT, 32'hFFFF_FFFB, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    wait_idle();

    // Start while busy is ignored
    issue(1'b1, OP_MULT, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F, 1'b0);
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_DIV;
    bus.a     = 32'h0000_0009;
    bus.b     = 32'h0000_0000;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();

    // Reset mid-operation discards it; next operation runs normally
    issue(1'b1, OP_MULT, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F, 1'b0);
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_MULT;
    bus.a     = 32'h0000_0009;
    bus.b     = 32'h0000_0009;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_hi", 64'(bus.hi), 64'd0);
    chk("midrst_lo", 64'(bus.lo), 64'd0);
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    chk("midrst_div_zero", 64'(bus.div_zero), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    issue(1'b1, OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Sequential signed multiply/divide unit for the multicycle MIPS datapath, driven by the control unit's `mult`/`div` states and feeding the HI/LO registers read by `mfhi`/`mflo`. It latches the two register-file operands (A, B) on a start pulse and iterates one bit per clock: radix-2 Booth for `mult`, restoring division for `div`. It reports completion with a one-cycle `done` pulse and reports division by zero with a one-cycle `div_zero` pulse, which the control unit routes to the exception path.

## Interface
- `WIDTH`, 32, operand width; HI and LO are each `WIDTH` bits.
- `clk`  input  1  system clock, rising-edge.
- `reset`  input  1  reset; asynchronous, active-high.
- `start`  input  1  request pulse; sampled only in IDLE.
- `op`  input  1  1 = mult, 0 = div (same encoding as the control unit's mult/div select).
- `a`  input  WIDTH  rs operand (multiplicand / dividend); latched at start.
- `b`  input  WIDTH  rt operand (multiplier / divisor); latched at start.
- `hi`  output  WIDTH  mult: upper product word; div: remainder.
- `lo`  output  WIDTH  mult: lower product word; div: quotient.
- `busy`  output  1  high while an operation is in flight.
- `done`  output  1  one-cycle pulse when `hi`/`lo` have been updated.
- `div_zero`  output  1  one-cycle pulse when a div is requested with `b == 0`.

## Operation
- States: IDLE, MULT, DIV, FIX.
- IDLE with `start = 1` and `op = 1`:
  - latch `a` and `b`, clear the 64-bit accumulator and the Booth extra bit;
  - iteration counter = 32; go to MULT.
- IDLE with `start = 1`, `op = 0`, `b != 0`:
  - latch |a|, |b| and the two operand signs; clear the remainder;
  - counter = 32; go to DIV.
- IDLE with `start = 1`, `op = 0`, `b == 0`:
  - pulse `div_zero`; stay in IDLE;
  - `hi`/`lo` unchanged; `busy` and `done` stay 0.
- MULT: one Booth step per cycle.
  - Inspect {q0, q-1}: 01 adds the multiplicand to the upper half, 10 subtracts it, 00/11 do nothing.
  - Then arithmetic right shift of the {upper, lower, q-1} register.
  - Decrement the counter; at zero go to FIX.
- DIV: one restoring step per cycle on magnitudes.
  - Shift {rem, quot} left by 1; trial = rem − |b|.
  - If trial is non-negative, rem = trial and the quotient LSB = 1.
  - Decrement the counter; at zero go to FIX.
- FIX:
  - mult: `hi` = upper word, `lo` = lower word.
  - div: `lo` = quotient, negated if the operand signs differ (truncation toward zero); `hi` = remainder, negated if `a` was negative.
  - Pulse `done`; return to IDLE.
- Arithmetic rules:
  - All arithmetic is two's complement, full 64-bit product.
  - 0x80000000 / −1 yields `lo` = 0x80000000, `hi` = 0, no flag.
- `start` outside IDLE is ignored; there is no queueing and no abort.
- Operand inputs are don't-care after the start cycle.
- `hi`/`lo` hold their last values until the next FIX; they are never partially updated.

## Timing
- Reset, asynchronous: state = IDLE, counter = 0, `hi` = `lo` = 0, `busy` = `done` = `div_zero` = 0.
  - Reset mid-operation discards the operation entirely.
  - The first start after reset release is accepted normally.
- Cycle numbering: start is sampled at edge E0.
  - `busy` = 1 from after E0 through E33.
  - Iterations occur at edges E1..E32.
  - FIX at E33 writes `hi`/`lo`; `done` = 1 in the cycle following E33 and `busy` = 0 then.
  - Latency from start to `done` is 34 cycles for both ops.
- Back-to-back: a start sampled in the same cycle `done` is high is accepted (IDLE).
- `div_zero` is high in the cycle after E0 only.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `mult_div_pkg`:
  - state enum (IDLE, MULT, DIV, FIX);
  - `OP_MULT` = 1'b1, `OP_DIV` = 1'b0;
  - `WIDTH` = 32; `ITER` = 32.
- Sub-module `div_step`: combinational restoring step.
  - Inputs: {rem, quot}, divisor.
  - Outputs: next {rem, quot}.
- The Booth step stays inline.

## Test plan
- mult a = 7, b = 0xFFFFFFFD (−3) -> `done` 34 cycles after start; `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFEB; `busy` high for exactly 33 cycles.
- mult a = b = 0x80000000 -> `hi` = 0x40000000, `lo` = 0x00000000; then mult 0xFFFFFFFF × 0xFFFFFFFF -> `hi` = 0, `lo` = 1.
- div a = 0xFFFFFFF9 (−7), b = 2 -> `lo` = 0xFFFFFFFD (−3), `hi` = 0xFFFFFFFF (−1); div 7 by −2 -> `lo` = 0xFFFFFFFD, `hi` = 1.
- Prior result `hi` = 0x11, `lo` = 0x22, then div 5 by 0 -> `div_zero` high for one cycle; `busy`/`done` never rise; `hi`/`lo` unchanged.
- div 0x80000000 by 0xFFFFFFFF -> `lo` = 0x80000000, `hi` = 0, `div_zero` = 0.
- Start a mult, pulse start with new operands at cycle 5 (ignored), assert reset at cycle 10 -> all outputs 0 immediately; a new div 100 by 7 then gives `lo` = 14, `hi` = 2 after 34 cycles.
